// File: rtl/sram_ctr_ahb_resp.sv
// AHB slave response stage of the SRAM controller: qualifies address phases, holds the
// address stage via error_check, drives the two-cycle ERROR response and the SRAM strobes.
module sram_ctr_ahb_resp #(
  parameter int                  ADDR_W  = 12,
  parameter logic [29-ADDR_W:0]  BASE_HI = '0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic        error_check,
  output logic        sram_ce,
  output logic        sram_we,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  // Handshake: an address phase is taken only when hsel & hready_in & htrans[1]
  // and the slave is not in the first (wait) cycle of an ERROR response.
  state_e      state_q, state_d;
  logic [3:0]  beats_q, beats_d;
  logic        sram_ce_q, sram_we_q;

  logic        is_seq, is_nonseq, fixed_burst, misaligned, out_of_range;
  logic        valid, illegal, accept;
  logic [3:0]  burst_len_m1;
  logic        unused_addr;

  assign unused_addr  = ^haddr[ADDR_W+1:2];
  assign is_seq       = (htrans == 2'b11);
  assign is_nonseq    = (htrans == 2'b10);
  assign fixed_burst  = hburst[2] | hburst[1];
  assign out_of_range = (haddr[31:ADDR_W+2] != BASE_HI);
  assign misaligned   = ((hsize == 3'd1) & haddr[0]) |
                        ((hsize == 3'd2) & (|haddr[1:0]));
  assign illegal      = out_of_range | (hsize > 3'd2) | misaligned |
                        (is_seq & fixed_burst & (beats_q == 4'd0));
  assign valid        = hsel & hready_in & htrans[1] & (state_q != ST_ERR1);
  assign accept       = valid & ~illegal;
  assign error_check  = ~accept | hreset;

  always_comb begin
    burst_len_m1 = 4'd0;
    case (hburst)
      3'd2, 3'd3: burst_len_m1 = 4'd3;
      3'd4, 3'd5: burst_len_m1 = 4'd7;
      3'd6, 3'd7: burst_len_m1 = 4'd15;
      default:    burst_len_m1 = 4'd0;
    endcase
  end

  // An ERROR response abandons the burst, so a following SEQ becomes illegal.
  always_comb begin
    beats_d = beats_q;
    if (valid & illegal)
      beats_d = 4'd0;
    else if (accept & is_nonseq)
      beats_d = burst_len_m1;
    else if (accept & is_seq & (beats_q != 4'd0))
      beats_d = beats_q - 4'd1;
  end

  // FSM: state register
  always_ff @(posedge hclk) begin
    if (hreset) state_q <= ST_OKAY;
    else        state_q <= state_d;
  end

  // FSM: next state; ERR2 holds while hready_in is low so the response is not cut short
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OKAY: if (valid & illegal) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: begin
        if (valid & illegal)  state_d = ST_ERR1;
        else if (hready_in)   state_d = ST_OKAY;
      end
      default: state_d = ST_OKAY;
    endcase
  end

  // FSM: outputs
  always_comb begin
    hready_out = 1'b1;
    hresp      = 2'b00;
    case (state_q)
      ST_ERR1: begin hready_out = 1'b0; hresp = 2'b01; end
      ST_ERR2: begin hready_out = 1'b1; hresp = 2'b01; end
      default: begin hready_out = 1'b1; hresp = 2'b00; end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      beats_q   <= 4'd0;
      sram_ce_q <= 1'b0;
      sram_we_q <= 1'b0;
    end else begin
      beats_q   <= beats_d;
      sram_ce_q <= accept;
      sram_we_q <= accept & hwrite;
    end
  end

  assign sram_ce   = sram_ce_q;
  assign sram_we   = sram_we_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_sram_ctr_ahb_resp.sv
// Bench for sram_ctr_ahb_resp: directed scenarios plus random bursts, checked against a
// transaction-level reference model through an expected-value queue.
module tb_sram_ctr_ahb_resp;

  localparam int ADDR_W = 12;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hburst = 3'd0;
  logic [2:0]  hsize = 3'd0;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic        hready_in = 1'b1;
  logic        hready_out;
  logic [1:0]  hresp;
  logic        error_check;
  logic        sram_ce;
  logic        sram_we;
  logic [1:0]  fsm_state;

  sram_ctr_ahb_resp #(.ADDR_W(ADDR_W), .BASE_HI(18'h0)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .haddr(haddr), .hready_in(hready_in),
    .hready_out(hready_out), .hresp(hresp), .error_check(error_check),
    .sram_ce(sram_ce), .sram_we(sram_we), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  // scoreboard: {hready_out, hresp[1:0], sram_ce, sram_we, error_check}
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model: error phase countdown (2 = wait cycle, 1 = final cycle),
  // remaining beats of the current fixed-length burst, and last-cycle strobes
  int   m_err = 0;
  int   m_rem = 0;
  logic m_ce  = 1'b0;
  logic m_we  = 1'b0;

  function automatic int burst_len(input logic [2:0] b);
    int lens[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    return lens[b];
  endfunction

  task automatic model_step();
    logic valid, illegal, accept, ec;
    int   sz;
    sz      = int'(hsize);
    valid   = hsel && hready_in && htrans[1] && (m_err != 2);
    illegal = ((haddr >> (ADDR_W + 2)) != 0) || (sz > 2) ||
              ((sz <= 2) && ((haddr % (32'd1 << sz)) != 0)) ||
              ((htrans == 2'b11) && (hburst >= 3'd2) && (m_rem == 0));
    accept  = valid && !illegal;
    ec      = !accept || hreset;
    exp_q.push_back({(m_err != 2), (m_err != 0) ? 2'b01 : 2'b00, m_ce, m_we, ec});
    if (hreset) begin
      m_err = 0; m_rem = 0; m_ce = 1'b0; m_we = 1'b0;
    end else begin
      m_ce = accept;
      m_we = accept && hwrite;
      if (valid && illegal) begin
        m_err = 2; m_rem = 0;
      end else begin
        if (m_err == 2) m_err = 1;
        else if (m_err == 1 && hready_in) m_err = 0;
        if (accept && htrans == 2'b10) m_rem = burst_len(hburst) - 1;
        else if (accept && htrans == 2'b11 && m_rem > 0) m_rem = m_rem - 1;
      end
    end
  endtask

  // driver
  task automatic drive(input logic rst, input logic sel, input logic rdy,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                       input logic wr, input logic [31:0] ad);
    @(posedge hclk);
    #2;
    hreset = rst; hsel = sel; hready_in = rdy; htrans = tr;
    hburst = bu; hsize = sz; hwrite = wr; haddr = ad;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 2'b00, 3'd0, 3'd2, 1'b0, 32'd0);
  endtask

  task automatic beat(input logic [1:0] tr, input logic [2:0] bu, input logic [2:0] sz,
                      input logic wr, input logic [31:0] ad);
    drive(1'b0, 1'b1, 1'b1, tr, bu, sz, wr, ad);
  endtask

  // monitor
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  always @(negedge hclk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hready_out",  {1'b0, hready_out},  {1'b0, e[5]});
      check("hresp",       hresp,               e[4:3]);
      check("sram_ce",     {1'b0, sram_ce},     {1'b0, e[2]});
      check("sram_we",     {1'b0, sram_we},     {1'b0, e[1]});
      check("error_check", {1'b0, error_check}, {1'b0, e[0]});
    end
  end

  initial begin
    logic [31:0] ad;
    logic [2:0]  bu, sz;
    logic        wr, rdy, sel;
    int          nb;

    // reset held two cycles
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 32'd0);
    idle(1);
    // SINGLE write
    beat(2'b10, 3'd0, 3'd2, 1'b1, 32'h10); idle(2);
    // out-of-range NONSEQ
    beat(2'b10, 3'd0, 3'd2, 1'b0, 32'h0001_0000); idle(3);
    // INCR4 read plus one surplus SEQ
    beat(2'b10, 3'd3, 3'd2, 1'b0, 32'h40);
    beat(2'b11, 3'd3, 3'd2, 1'b0, 32'h44);
    beat(2'b11, 3'd3, 3'd2, 1'b0, 32'h48);
    beat(2'b11, 3'd3, 3'd2, 1'b0, 32'h4C);
    beat(2'b11, 3'd3, 3'd2, 1'b0, 32'h50); idle(3);
    // alignment
    beat(2'b10, 3'd0, 3'd2, 1'b0, 32'h6); idle(3);
    beat(2'b10, 3'd0, 3'd1, 1'b0, 32'h6); idle(2);
    // illegal then legal NONSEQ issued during ERR2
    beat(2'b10, 3'd0, 3'd2, 1'b0, 32'h3);
    idle(1);
    beat(2'b10, 3'd0, 3'd2, 1'b1, 32'h20); idle(2);
    // reset during the response
    beat(2'b10, 3'd0, 3'd3, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 32'd0);
    idle(2);
    // hready_in low during ERR2, then SEQ after an aborted burst
    beat(2'b10, 3'd2, 3'd2, 1'b0, 32'h0010_0000);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 3'd0, 3'd2, 1'b0, 32'h8);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 3'd2, 1'b0, 32'h8);
    idle(2);
    beat(2'b10, 3'd2, 3'd2, 1'b0, 32'h100);
    beat(2'b11, 3'd2, 3'd3, 1'b0, 32'h104);
    idle(1);
    beat(2'b11, 3'd2, 3'd2, 1'b0, 32'h108); idle(3);

    // random bursts
    for (int n = 0; n < 300; n++) begin
      bu = 3'($urandom_range(0, 7));
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      ad = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 19) == 0) ad[20] = 1'b1;
      if ($urandom_range(0, 19) == 0) ad[0]  = 1'b1;
      nb = (bu >= 3'd2) ? burst_len(bu) - 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
      for (int b = 0; b <= nb; b++) begin
        rdy = ($urandom_range(0, 7) != 0);
        sel = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 7) == 0)
          drive(1'b0, sel, rdy, 2'($urandom_range(0, 1)), bu, sz, wr, ad);
        drive(($urandom_range(0, 299) == 0), sel, rdy, (b == 0) ? 2'b10 : 2'b11,
              bu, sz, wr, ad);
        ad = ad + (32'd1 << (sz & 3'd3));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge hclk);
    @(posedge hclk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
